serial_adder: RTL and testbench

Bit-serial adder that reuses a single full-adder cell over multiple clock cycles. It accepts two WIDTH-bit operands and a carry-in, adds them LSB-first (one bit per cycle) through a registered carry, and presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits directly downstream of the combinational full adder: it instantiates that cell as its per-bit datapath and sequences it into a multi-bit adder.

---
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder sequencing one full-adder cell over WIDTH cycles

// Single-bit full adder used as the per-bit datapath of the serial adder.
module serial_adder_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  // Sum bit and majority carry
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// LSB-first adder: one bit per clock through a registered carry, with done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Counter value on the edge that consumes the final (MSB) bit
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_c;
  logic [WIDTH-1:0] r_racc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic w_s;
  logic w_carry_next;
  logic w_accept;

  serial_adder_fa u_fa (
    .i_a (r_ra[0]),
    .i_b (r_rb[0]),
    .i_c (r_c),
    .o_s (w_s),
    .o_c (w_carry_next)
  );

  // A new operation may be accepted from IDLE or from the DONE cycle (back-to-back)
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Operand capture, per-bit shifting and result latching
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_c     <= 1'b0;
      r_racc  <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_ra    <= a;
      r_rb    <= b;
      r_c     <= cin;
      r_racc  <= '0;
      r_cnt   <= '0;
      r_state <= S_SHIFT;
    end else if (r_state == S_SHIFT) begin
      r_racc <= {w_s, r_racc[WIDTH-1:1]};
      r_ra   <= r_ra >> 1;
      r_rb   <= r_rb >> 1;
      r_c    <= w_carry_next;
      r_cnt  <= r_cnt + 1'b1;
      if (r_cnt == LAST_BIT) begin
        // sum/cout only change here, so they hold through any later SHIFT
        r_sum   <= {w_s, r_racc[WIDTH-1:1]};
        r_cout  <= w_carry_next;
        r_state <= S_DONE;
      end
    end else begin
      // DONE without start, or an unreachable encoding, returns to IDLE
      r_state <= S_IDLE;
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder (WIDTH=8 and WIDTH=4)
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4;
  logic [3:0] sum4;
  logic       cout4;

  int n_vec;
  int n_err;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one WIDTH=8 operation; report edges from acceptance (incl. the accepting edge) to done,
  // and the number of sampled cycles with busy high before done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [8:0] res, output int lat, output int bcnt);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx; cin8 = 1'bx;
    lat = 1; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
    res = {cout8, sum8};
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                      output logic [4:0] res, output int lat);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = {cout4, sum4};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      n_err++;
      $display("FAIL reset8: busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    n_vec++;
    if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      n_err++;
      $display("FAIL reset4: busy=%b done=%b cout=%b sum=%h, want all 0", busy4, done4, cout4, sum4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [8:0] res;
    int lat, bcnt;
    run8(8'h3C, 8'h0F, 1'b0, res, lat, bcnt);
    n_vec++;
    if (res !== 9'h04B) begin
      n_err++;
      $display("FAIL basic_sum: got %h, want 04b", res);
    end
    n_vec++;
    if (lat !== 9) begin
      n_err++;
      $display("FAIL basic_latency: got %0d edges, want 9", lat);
    end
    n_vec++;
    if (bcnt !== 8) begin
      n_err++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", bcnt);
    end
    n_vec++;
    if (busy8 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy_with_done: busy=%b, want 0", busy8);
    end
    @(negedge clk);
    n_vec++;
    if (done8 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_width: done=%b on second cycle, want 0", done8);
    end
  endtask

  task automatic test_carry;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vc [3];
    logic [8:0] vexp [3];
    logic [8:0] res;
    int lat, bcnt;
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; vexp[0] = 9'h100;
    va[1] = 8'hA5; vb[1] = 8'h5A; vc[1] = 1'b1; vexp[1] = 9'h100;
    va[2] = 8'h00; vb[2] = 8'h00; vc[2] = 1'b1; vexp[2] = 9'h001;
    for (int i = 0; i < 3; i++) begin
      run8(va[i], vb[i], vc[i], res, lat, bcnt);
      n_vec++;
      if (res !== vexp[i] || lat !== 9) begin
        n_err++;
        $display("FAIL carry_%0d: got %h lat %0d, want %h lat 9", i, res, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int dones;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) begin
        dones++;
        n_vec++;
        if ({cout8, sum8} !== 9'h030) begin
          n_err++;
          $display("FAIL busy_start_result: got %h, want 030", {cout8, sum8});
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (dones !== 1) begin
      n_err++;
      $display("FAIL busy_start_done_count: got %0d, want 1", dones);
    end
    n_vec++;
    if ({cout8, sum8} !== 9'h030 || busy8 !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_hold: got %h busy %b, want 030 busy 0", {cout8, sum8}, busy8);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if ({cout8, sum8} !== 9'h046) begin
      n_err++;
      $display("FAIL b2b_first: got %h, want 046", {cout8, sum8});
    end
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b done=%b, want busy 1 done 0", busy8, done8);
    end
    n_vec++;
    if ({cout8, sum8} !== 9'h046) begin
      n_err++;
      $display("FAIL b2b_hold_in_shift: got %h, want 046", {cout8, sum8});
    end
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    n_vec++;
    if ({cout8, sum8} !== 9'h100 || lat !== 9) begin
      n_err++;
      $display("FAIL b2b_second: got %h lat %0d, want 100 lat 9", {cout8, sum8}, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic [8:0] res;
    int lat, bcnt, dones;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || {cout8, sum8} !== 9'h000) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b done=%b res=%h, want 0 0 000", busy8, done8, {cout8, sum8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    n_vec++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL mid_reset_no_done: %0d active cycles, want 0", dones);
    end
    run8(8'h01, 8'h02, 1'b0, res, lat, bcnt);
    n_vec++;
    if (res !== 9'h003) begin
      n_err++;
      $display("FAIL mid_reset_after: got %h, want 003", res);
    end
  endtask

  task automatic test_exhaustive4;
    logic [4:0] res;
    logic [4:0] exp_v;
    int lat;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          exp_v = 5'(ia + ib + ic);
          run4(4'(ia), 4'(ib), 1'(ic), res, lat);
          n_vec++;
          if (res !== exp_v || lat !== 5) begin
            n_err++;
            $display("FAIL exh4 a=%0d b=%0d c=%0d: got %h lat %0d, want %h lat 5",
                     ia, ib, ic, res, lat, exp_v);
          end
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_basic;
    test_carry;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid_op;
    test_exhaustive4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
